// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - segmented multi-cycle WIDTH-bit adder sequencer (optional ADD_SEQ_ACC_EN accumulate mode)
module add_seq_ctrl #(
   parameter int WIDTH = 512,
   parameter int SEG   = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
`ifdef ADD_SEQ_ACC_EN
   input  logic             acc,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic             cout,
   output logic             busy
);

   localparam int NSEG = WIDTH / SEG;
   localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
   localparam logic [CW-1:0] LAST_SEG = CW'(NSEG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    seg_cnt_q, seg_cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             cout_q, cout_d;

   logic [SEG-1:0]   a_seg;
   logic [SEG-1:0]   b_seg;
   logic [SEG:0]     seg_sum;

   assign in_ready  = (state_q == IDLE) & en;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign res       = res_q;
   assign cout      = cout_q;

   // Shared adder slice: current segment of both operands plus the chained carry
   always_comb begin
      a_seg   = a_q[int'(seg_cnt_q) * SEG +: SEG];
      b_seg   = b_q[int'(seg_cnt_q) * SEG +: SEG];
      seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, carry_q};
   end

   // Next-state and datapath update; everything holds while en is low
   always_comb begin
      state_d   = state_q;
      seg_cnt_d = seg_cnt_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      cout_d    = cout_q;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a_d = A_in;
`ifdef ADD_SEQ_ACC_EN
                  b_d = acc ? res_q : B_in;
`else
                  b_d = B_in;
`endif
                  carry_d   = 1'b0;
                  seg_cnt_d = '0;
                  state_d   = RUN;
               end
            end
            RUN: begin
               res_d[int'(seg_cnt_q) * SEG +: SEG] = seg_sum[SEG-1:0];
               carry_d   = seg_sum[SEG];
               seg_cnt_d = seg_cnt_q + CW'(1);
               if (seg_cnt_q == LAST_SEG) begin
                  cout_d    = seg_sum[SEG];
                  seg_cnt_d = '0;
                  state_d   = DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         seg_cnt_q <= '0;
         carry_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         seg_cnt_q <= seg_cnt_d;
         carry_q   <= carry_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         cout_q    <= cout_d;
      end
   end

endmodule
